// File: rtl/dmem_arbiter.sv
// Two-requester arbiter sharing the single-port data RAM between the CPU data port (C)
// and the DMA/vector loader port (D). One access per three cycles: IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
    parameter int unsigned FIXED_PRI = 0,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t state;
    logic   last;
    logic   owner;
    logic   grant_c;

    // Winner selection for the IDLE cycle; only meaningful when some request is high.
    always_comb begin
        grant_c = 1'b0;
        if (c_req && !d_req) begin
            grant_c = 1'b1;
        end else if (c_req && d_req) begin
            grant_c = (FIXED_PRI != 0) || (last == OWN_D);
        end
    end

    // mem_addr/mem_datain double as the latched request; mem_we is the latched we,
    // raised only for the ACCESS cycle so no write can happen elsewhere.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            last       <= OWN_D;
            owner      <= OWN_C;
            mem_addr   <= '0;
            mem_datain <= '0;
            mem_we     <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (c_req || d_req) begin
                        owner      <= grant_c ? OWN_C : OWN_D;
                        mem_addr   <= grant_c ? c_addr : d_addr;
                        mem_datain <= grant_c ? c_wdata : d_wdata;
                        mem_we     <= grant_c ? c_we : d_we;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM read is combinational, so a write cycle captures the old word.
                    mem_we <= 1'b0;
                    if (owner == OWN_C) begin
                        c_rdata <= mem_dataout;
                    end else begin
                        d_rdata <= mem_dataout;
                    end
                    c_ack <= (owner == OWN_C);
                    d_ack <= (owner == OWN_D);
                    last  <= owner;
                    state <= RESP;
                end
                RESP: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    c_ack  <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance used for the contention case.
module tb_dmem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic init = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] c_rdata, d_rdata, mem_addr, mem_datain, mem_dataout;
    logic        c_ack, d_ack, mem_we, busy;

    logic        c1_req = 1'b0, d1_req = 1'b0;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_datain, m1_dout;
    logic        c1_ack, d1_ack, m1_we, busy1;

    logic [31:0] ram [32];
    exp_t qc[$], qd[$], q1c[$];

    dmem_arbiter #(.FIXED_PRI(0)) u0 (
        .clk(clk), .clrn(clrn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
        .mem_dataout(mem_dataout), .busy(busy)
    );

    dmem_arbiter #(.FIXED_PRI(1)) u1 (
        .clk(clk), .clrn(clrn),
        .c_req(c1_req), .c_we(1'b0), .c_addr(32'h10), .c_wdata(32'h0),
        .c_rdata(c1_rdata), .c_ack(c1_ack),
        .d_req(d1_req), .d_we(1'b0), .d_addr(32'h14), .d_wdata(32'h0),
        .d_rdata(d1_rdata), .d_ack(d1_ack),
        .mem_addr(m1_addr), .mem_datain(m1_datain), .mem_we(m1_we),
        .mem_dataout(m1_dout), .busy(busy1)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, synchronous write; preloaded once.
    assign mem_dataout = ram[mem_addr[6:2]];
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 32; i++) ram[i] <= (i == 18) ? 32'h2 : 32'h7fff_ffff;
        end else if (mem_we) begin
            ram[mem_addr[6:2]] <= mem_datain;
        end
    end

    // Read-only stand-in for the fixed-priority instance's RAM.
    assign m1_dout = 32'h1000_0000 | m1_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every ack pops the matching port's queue and checks data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (clrn === 1'b1) begin
            if (c_ack) begin
                if (qc.size() == 0) chk("c_ack spurious", 32'(c_ack), 32'h0);
                else begin
                    e = qc.pop_front();
                    chk("c_rdata", c_rdata, e.rdata);
                    chk("c_ack cycle", cyc, e.cyc);
                end
            end
            if (d_ack) begin
                if (qd.size() == 0) chk("d_ack spurious", 32'(d_ack), 32'h0);
                else begin
                    e = qd.pop_front();
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_ack cycle", cyc, e.cyc);
                end
            end
            if (c1_ack) begin
                if (q1c.size() == 0) chk("fp c_ack spurious", 32'(c1_ack), 32'h0);
                else begin
                    e = q1c.pop_front();
                    chk("fp c_rdata", c1_rdata, e.rdata);
                    chk("fp c_ack cycle", cyc, e.cyc);
                end
            end
            if (d1_ack) chk("fp d_ack", 32'(d1_ack), 32'h0);
        end
    end

    initial begin
        tick(2);
        init = 1'b0;
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst c_ack", 32'(c_ack), 32'h0);
        chk("rst d_ack", 32'(d_ack), 32'h0);
        chk("rst c_rdata", c_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        clrn = 1'b1;
        tick(1);

        // No requests for 20 cycles
        repeat (20) begin
            @(negedge clk);
            chk("idle mem_we", 32'(mem_we), 32'h0);
            chk("idle busy", 32'(busy), 32'h0);
            chk("idle c_ack", 32'(c_ack), 32'h0);
            chk("idle d_ack", 32'(d_ack), 32'h0);
        end
        tick(1);

        // C read of word 0x12
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h48;
        qc.push_back('{32'h2, cyc + 2});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1 mem_we", 32'(mem_we), 32'h0);
        end
        tick(1);
        c_req = 1'b0;
        tick(3);

        // Simultaneous C write / D read of 0x60 after reset
        clrn = 1'b0;
        tick(1);
        clrn = 1'b1;
        tick(1);
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h60; c_wdata = 32'h258;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        qc.push_back('{32'h7fff_ffff, cyc + 2});
        qd.push_back('{32'h258, cyc + 5});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2 mem_we", 32'(mem_we), (i == 1) ? 32'h1 : 32'h0);
        end
        tick(1);
        c_req = 1'b0; c_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2 mem_we d", 32'(mem_we), 32'h0);
        end
        tick(1);
        d_req = 1'b0;
        tick(2);

        // Both requesters held for six accesses on each instance
        c_addr = 32'h48; d_addr = 32'h60;
        c_req = 1'b1; d_req = 1'b1; c1_req = 1'b1; d1_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            qc.push_back('{32'h2, cyc + 2 + 6 * k});
            qd.push_back('{32'h258, cyc + 5 + 6 * k});
        end
        for (int k = 0; k < 6; k++) q1c.push_back('{32'h1000_0010, cyc + 2 + 3 * k});
        tick(18);
        c_req = 1'b0; d_req = 1'b0; c1_req = 1'b0; d1_req = 1'b0;
        tick(2);

        // D write while C request toggles during ACCESS
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h30;
        qd.push_back('{32'h7fff_ffff, cyc + 2});
        tick(1);
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h4c; c_wdata = 32'hffff_ffff;
        tick(1);
        c_req = 1'b0; c_we = 1'b0;
        tick(1);
        d_req = 1'b0; d_we = 1'b0;
        chk("t4 c_rdata held", c_rdata, 32'h2);
        chk("t4 ram word 8", ram[8], 32'h30);
        c_addr = 32'h20; c_req = 1'b1;
        qc.push_back('{32'h30, cyc + 2});
        tick(3);
        c_req = 1'b0;
        tick(2);

        // Reset in the middle of a C write's ACCESS cycle
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h4c; c_wdata = 32'hdead_beef;
        tick(1);
        chk("t5 mem_we before reset", 32'(mem_we), 32'h1);
        #2 clrn = 1'b0;
        #1;
        chk("t5 mem_we", 32'(mem_we), 32'h0);
        chk("t5 busy", 32'(busy), 32'h0);
        chk("t5 c_rdata", c_rdata, 32'h0);
        chk("t5 d_rdata", d_rdata, 32'h0);
        chk("t5 c_ack", 32'(c_ack), 32'h0);
        c_req = 1'b0; c_we = 1'b0;
        tick(2);
        clrn = 1'b1;
        tick(4);
        chk("t5 ram word 0x13", ram[19], 32'h7fff_ffff);
        chk("t5 busy after", 32'(busy), 32'h0);

        chk("c queue drained", 32'(qc.size()), 32'h0);
        chk("d queue drained", 32'(qd.size()), 32'h0);
        chk("fp c queue drained", 32'(q1c.size()), 32'h0);
        chk("fp d_rdata", d1_rdata, 32'h0);
        chk("fp mem_we", 32'(m1_we), 32'h0);
        chk("fp mem_datain", m1_datain, 32'h0);
        chk("fp busy", 32'(busy1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 32-word data RAM of the multi-cycle CPU between the CPU data port (C) and a DMA/interrupt-vector loader port (D).
- The RAM has combinational read on addr[6:2] and a synchronous write when we=1. The arbiter serialises accesses, owns mem_we, registers read data, and returns a one-cycle ack to the winning requester.

Parameters:
- FIXED_PRI, 0, 0 = round-robin between C and D; 1 = C always wins a tie.
- DATA_W, 32, data width of both ports and of the RAM.
- ADDR_W, 32, byte-address width, passed through unchanged to the RAM.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clrn  input  1  asynchronous active-low reset.
- c_req  input  1  C request; held until c_ack.
- c_we  input  1  C write enable, qualified by c_req.
- c_addr  input  ADDR_W  C byte address.
- c_wdata  input  DATA_W  C write data.
- c_rdata  output  DATA_W  C read data, registered.
- c_ack  output  1  one-cycle completion pulse to C.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_ack: same directions, widths and meanings for D.
- mem_addr  output  ADDR_W  RAM address.
- mem_datain  output  DATA_W  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_dataout  input  DATA_W  RAM combinational read data.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, last=D, so C wins the first tie.
  - c_ack=d_ack=0, c_rdata=d_rdata=0, mem_we=0.
  - Latched addr/wdata/we/owner cleared to 0.
- The FSM has three states, with one access every 3 cycles:
  - IDLE: if no request, stay in IDLE. Otherwise choose a winner, latch its addr, wdata and we plus the owner ID, then go to ACCESS.
  - ACCESS: mem_addr, mem_datain and mem_we are driven from the latched registers. If the latched we=1, the RAM writes on this cycle's closing edge. On that same edge, mem_dataout is captured into the owner's rdata register; a captured write returns the pre-write word. Go to RESP; last <= owner.
  - RESP: the owner's ack=1 for exactly this cycle and its rdata is valid. Go to IDLE.
- Winner selection in IDLE:
  - Only one req high: that requester wins.
  - Both high, FIXED_PRI=1: C wins.
  - Both high, FIXED_PRI=0: the requester that is not last wins.
- Requests are sampled only in IDLE. Changes to req/addr/wdata/we during ACCESS or RESP are ignored.
- A requester that keeps req high in the cycle after its ack makes a new request (back-to-back access). With FIXED_PRI=0 and both requesters continuously requesting, grants alternate C,D,C,D.
- mem_we=0 in IDLE and RESP: no write ever occurs outside ACCESS. In IDLE and RESP, mem_addr and mem_datain hold the last latched values.
- rdata of the non-owner is never modified. Each rdata holds its value until that port's next completed access.
- Address: full ADDR_W passed through; no alignment check. The RAM ignores bits [1:0] and [31:7].
- Reset asserted during ACCESS: mem_we drops immediately and no write is performed if clrn is low at the edge. No ack is issued and the state returns to IDLE; the requester must re-request.
- Reset asserted during RESP: the ack is removed immediately.
- Latency from req sampled in IDLE to ack: 2 cycles (ack in the 3rd cycle).

Test Plan:
- RAM word 0x12=0x00000002. C read c_addr=0x48, D idle -> c_ack high exactly in cycle 3, c_rdata=0x00000002, mem_we never 1, d_ack stays 0.
- Same cycle: C write addr 0x60, data 0x00000258; D read addr 0x60; FIXED_PRI=0, after reset -> C served first (mem_we=1 in cycle 2 only), then D gets d_rdata=0x00000258 with d_ack in cycle 6.
- Both req held high for 6 accesses, FIXED_PRI=0 -> ack order C,D,C,D,C,D with one access per 3 cycles. With FIXED_PRI=1 -> six consecutive c_ack and no d_ack.
- D writes 0x00000030 to 0x20 while C req toggles during ACCESS -> C toggle ignored, word 0x8 reads 0x00000030, c_rdata unchanged.
- clrn pulled low mid-ACCESS of a C write of 0xDEADBEEF to 0x4C -> no write (word 0x13 stays 0x7fffffff), no c_ack, busy=0, all rdata=0.
- Idle for 20 cycles with no req -> mem_we=0, busy=0, both acks 0 throughout.
